// File: rtl/reset_seq_gen.sv
// rtl/reset_seq_gen.sv - staggered per-domain reset release sequencer
module reset_seq_gen #(
    parameter int NUM_OUT        = 4,
    parameter int ASSERT_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic               Clock,
    input  logic               qReset,
    input  logic               qLock,
    input  logic               qRstReq,
    output logic [NUM_OUT-1:0] qnRstOut,
    output logic               qRstBusy,
    output logic               qRstDone
);

    localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int MAX_CYC = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
    localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_OUT - 1);

    if (NUM_OUT < 1) begin : g_bad_num_out
        $error("reset_seq_gen: NUM_OUT must be >= 1");
    end
    if (ASSERT_CYCLES < 2) begin : g_bad_assert
        $error("reset_seq_gen: ASSERT_CYCLES must be >= 2");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("reset_seq_gen: STAGGER_CYCLES must be >= 1");
    end
    if ((CNT_W < 1) || ((CNT_W < 31) && ((MAX_CYC - 1) >= (1 << CNT_W)))) begin : g_bad_cnt_w
        $error("reset_seq_gen: CNT_W too small for the cycle counts");
    end

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [NUM_OUT-1:0] rst_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               abort;
    logic               assert_term;
    logic               stagger_term;
    logic               last_idx;

    // Lock loss and soft request are treated identically everywhere.
    assign abort        = !qLock || qRstReq;
    assign assert_term  = (cnt_q == ASSERT_LAST);
    assign stagger_term = (cnt_q == STAGGER_LAST);
    assign last_idx     = (idx_q == LAST_IDX);

    always_ff @(posedge Clock or posedge qReset) begin
        if (qReset) begin
            state_q  <= ST_ASSERT;
            cnt_q    <= '0;
            idx_q    <= '0;
            qnRstOut <= '0;
            qRstBusy <= 1'b1;
            qRstDone <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            qnRstOut <= rst_nxt;
            qRstBusy <= busy_nxt;
            qRstDone <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        case (state_q)
            ST_ASSERT: begin
                if (abort) begin
                    cnt_nxt = '0;
                end else if (assert_term) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (stagger_term) begin
                    cnt_nxt = '0;
                    if (last_idx) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; released bits stay high until abort.
    always_comb begin
        rst_nxt  = qnRstOut;
        busy_nxt = 1'b1;
        done_nxt = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                rst_nxt = '0;
                if (!abort && assert_term) begin
                    rst_nxt[0] = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    rst_nxt = '0;
                end else if (stagger_term) begin
                    if (last_idx) begin
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        for (int i = 1; i < NUM_OUT; i++) begin
                            if (i == int'(idx_q) + 1) begin
                                rst_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (abort) begin
                    rst_nxt = '0;
                end else begin
                    rst_nxt  = '1;
                    busy_nxt = 1'b0;
                end
            end
            default: begin
                rst_nxt = '0;
            end
        endcase
    end

endmodule
